// File: rtl/tmp_seq_pkg.sv
// Shared types and helpers for the temperature-sensor sequencer.
package tmp_seq_pkg;

  typedef enum logic [2:0] {
    TMP_IDLE      = 3'd0,
    TMP_PRECHARGE = 3'd1,
    TMP_BLANK_D   = 3'd2,
    TMP_DIODE     = 3'd3,
    TMP_BLANK_B   = 3'd4,
    TMP_BIGDIODE  = 3'd5,
    TMP_CHARGE    = 3'd6,
    TMP_OUTPUT    = 3'd7
  } tmp_state_t;

  typedef struct packed {
    logic pa;
    logic pb;
    logic pc;
    logic pd;
    logic pi1;
    logic pi2;
    logic pii1;
    logic pii2;
  } tmp_sw_t;

  // Cycles spent on one delta-sigma decision: two blanks, diode, big-diode, charge.
  function automatic int decision_cycles(input int diode_cyc, input int big_cyc);
    return diode_cyc + big_cyc + 3;
  endfunction

endpackage

// File: rtl/tmp_seq_if.sv
// Front-end / readout signal bundle of the temperature-sensor sequencer.
interface tmp_seq_if #(
  parameter int NCH     = 2,
  parameter int OSR_LOG = 6
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic             cmp;
  logic             start;
  logic             cont;
  logic             PI1, PI2, PII1, PII2;
  logic             PA, PB, PC, PD;
  logic             src_n, snk;
  logic             cmp_p1, cmp_p2;
  logic             sample;
  logic             preChrg, setupBias;
  logic [NCH-1:0]   ch_sel;
  logic             busy;
  logic             valid;
  logic [OSR_LOG:0] code;
  logic [CHW-1:0]   code_ch;

  modport master (
    output cmp, start, cont,
    input  PI1, PI2, PII1, PII2, PA, PB, PC, PD, src_n, snk,
    input  cmp_p1, cmp_p2, sample, preChrg, setupBias,
    input  ch_sel, busy, valid, code, code_ch
  );

  modport slave (
    input  cmp, start, cont,
    output PI1, PI2, PII1, PII2, PA, PB, PC, PD, src_n, snk,
    output cmp_p1, cmp_p2, sample, preChrg, setupBias,
    output ch_sel, busy, valid, code, code_ch
  );
endinterface

// File: rtl/tmp_seq_chop.sv
// Free-running comparator chopper: complementary clocks toggling every CHOP_DIV
// cycles, with a sample strobe in the cycle before each toggle.
module tmp_chop #(
  parameter int CHOP_DIV = 3
) (
  input  logic clk,
  input  logic reset,
  output logic cmp_p1,
  output logic cmp_p2,
  output logic sample
);
  localparam int DW = $clog2(CHOP_DIV);
  localparam logic [DW-1:0] LD = DW'(CHOP_DIV - 1);

  logic [DW-1:0] cnt_q, cnt_d;
  logic          p1_q, p1_d;
  logic          p2_q, p2_d;
  logic          smp_q, smp_d;

  always_comb begin
    cnt_d = cnt_q - DW'(1);
    p1_d  = p1_q;
    if (cnt_q == '0) begin
      cnt_d = LD;
      p1_d  = ~p1_q;
    end
    p2_d  = ~p1_d;
    smp_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= LD;
      p1_q  <= 1'b0;
      p2_q  <= 1'b1;
      smp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      p1_q  <= p1_d;
      p2_q  <= p2_d;
      smp_q <= smp_d;
    end
  end

  assign cmp_p1 = p1_q;
  assign cmp_p2 = p2_q;
  assign sample = smp_q;
endmodule

// File: rtl/tmp_seq.sv
// Multi-channel temperature-sensor sequencer: switched-capacitor phase FSM,
// first-order delta-sigma decision loop and per-channel ones-count result.
module tmp_seq
  import tmp_seq_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int PRE_CYC   = 11,
  parameter int DIODE_CYC = 1,
  parameter int BIG_CYC   = 5,
  parameter int SETUP_DEC = 6,
  parameter int OSR_LOG   = 6,
  parameter int CHOP_DIV  = 3
) (
  input logic     clk,
  input logic     reset,
  tmp_seq_if.slave io
);
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW    = OSR_LOG + 1;
  localparam int SW    = (SETUP_DEC > 0) ? $clog2(SETUP_DEC + 1) : 1;
  localparam int TMAX0 = (PRE_CYC > DIODE_CYC) ? PRE_CYC : DIODE_CYC;
  localparam int TMAX  = (TMAX0 > BIG_CYC) ? TMAX0 : BIG_CYC;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [TW-1:0]  PRE_LD   = TW'(PRE_CYC - 1);
  localparam logic [TW-1:0]  DIO_LD   = TW'(DIODE_CYC - 1);
  localparam logic [TW-1:0]  BIG_LD   = TW'(BIG_CYC - 1);
  localparam logic [CW-1:0]  DEC_FULL = CW'(2 ** OSR_LOG);
  localparam logic [SW-1:0]  SETUP_N  = SW'(SETUP_DEC);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(NCH - 1);

  localparam logic [2:0] ST_IDLE   = TMP_IDLE;
  localparam logic [2:0] ST_PRE    = TMP_PRECHARGE;
  localparam logic [2:0] ST_BLK_D  = TMP_BLANK_D;
  localparam logic [2:0] ST_DIODE  = TMP_DIODE;
  localparam logic [2:0] ST_BLK_B  = TMP_BLANK_B;
  localparam logic [2:0] ST_BIG    = TMP_BIGDIODE;
  localparam logic [2:0] ST_CHARGE = TMP_CHARGE;
  localparam logic [2:0] ST_OUTPUT = TMP_OUTPUT;

  logic [2:0]     state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [CW-1:0]  dec_q, dec_d;
  logic [CW-1:0]  ones_q, ones_d;
  logic [SW-1:0]  setup_q, setup_d;
  tmp_sw_t        sw_q, sw_d;
  logic           src_n_q, src_n_d;
  logic           snk_q, snk_d;
  logic           pre_q, pre_d;
  logic           sbias_q, sbias_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;
  logic [NCH-1:0] ch_sel_q, ch_sel_d;
  logic [CW-1:0]  code_q, code_d;
  logic [CHW-1:0] code_ch_q, code_ch_d;
  logic           tc;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    tmr_d     = tmr_q;
    dec_d     = dec_q;
    ones_d    = ones_q;
    setup_d   = setup_q;
    code_d    = code_q;
    code_ch_d = code_ch_q;
    tc        = (tmr_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (io.start) begin
          state_d = ST_PRE;
          ch_d    = '0;
          tmr_d   = PRE_LD;
        end
      end
      ST_PRE: begin
        if (tc) state_d = ST_BLK_D;
        else    tmr_d   = tmr_q - TW'(1);
      end
      ST_BLK_D: begin
        state_d = ST_DIODE;
        tmr_d   = DIO_LD;
      end
      ST_DIODE: begin
        if (tc) state_d = ST_BLK_B;
        else    tmr_d   = tmr_q - TW'(1);
      end
      ST_BLK_B: begin
        state_d = ST_BIG;
        tmr_d   = BIG_LD;
      end
      ST_BIG: begin
        // The decision is the comparator value latched on the last big-diode cycle.
        if (tc) begin
          state_d = ST_CHARGE;
          if (setup_q < SETUP_N) begin
            setup_d = setup_q + SW'(1);
          end else begin
            ones_d = ones_q + CW'(io.cmp);
            dec_d  = dec_q + CW'(1);
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      ST_CHARGE: begin
        state_d = (dec_q == DEC_FULL) ? ST_OUTPUT : ST_BLK_D;
      end
      ST_OUTPUT: begin
        if (ch_q != CH_LAST) begin
          state_d = ST_PRE;
          ch_d    = ch_q + CHW'(1);
          tmr_d   = PRE_LD;
        end else if (io.cont) begin
          state_d = ST_PRE;
          ch_d    = '0;
          tmr_d   = PRE_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_PRE) begin
      dec_d   = '0;
      ones_d  = '0;
      setup_d = '0;
    end

    // Registered outputs are derived from the next state so they line up with it.
    sw_d    = '0;
    src_n_d = 1'b0;
    snk_d   = 1'b0;
    pre_d   = 1'b0;
    valid_d = 1'b0;
    case (state_d)
      ST_PRE: begin
        sw_d.pb = 1'b1;
        sw_d.pc = 1'b1;
        sw_d.pd = 1'b1;
        pre_d   = 1'b1;
      end
      ST_DIODE: begin
        sw_d.pii1 = 1'b1;
        sw_d.pii2 = 1'b1;
      end
      ST_BIG: begin
        sw_d.pi1 = 1'b1;
        sw_d.pi2 = 1'b1;
        src_n_d  = ((state_q == ST_BIG) ? src_n_q : 1'b0) ^ io.cmp;
        snk_d    = ((state_q == ST_BIG) ? snk_q : 1'b0) ^ ~io.cmp;
      end
      ST_CHARGE: begin
        sw_d.pa = 1'b1;
        sw_d.pb = io.cmp;
        sw_d.pc = ~io.cmp;
      end
      ST_OUTPUT: begin
        sw_d.pb   = 1'b1;
        sw_d.pc   = 1'b1;
        sw_d.pd   = 1'b1;
        valid_d   = 1'b1;
        code_d    = ones_q;
        code_ch_d = ch_q;
      end
      default: ;
    endcase

    sbias_d = sbias_q;
    if (state_d == ST_PRE)
      sbias_d = 1'b1;
    else if (state_d == ST_IDLE)
      sbias_d = 1'b0;
    else if (state_d == ST_CHARGE && state_q == ST_BIG && setup_d == SETUP_N)
      sbias_d = 1'b0;

    busy_d   = (state_d != ST_IDLE);
    ch_sel_d = busy_d ? (NCH'(1) << ch_d) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      tmr_q     <= '0;
      dec_q     <= '0;
      ones_q    <= '0;
      setup_q   <= '0;
      sw_q      <= '0;
      src_n_q   <= 1'b0;
      snk_q     <= 1'b0;
      pre_q     <= 1'b0;
      sbias_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      ch_sel_q  <= '0;
      code_q    <= '0;
      code_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      tmr_q     <= tmr_d;
      dec_q     <= dec_d;
      ones_q    <= ones_d;
      setup_q   <= setup_d;
      sw_q      <= sw_d;
      src_n_q   <= src_n_d;
      snk_q     <= snk_d;
      pre_q     <= pre_d;
      sbias_q   <= sbias_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      ch_sel_q  <= ch_sel_d;
      code_q    <= code_d;
      code_ch_q <= code_ch_d;
    end
  end

  assign io.PA        = sw_q.pa;
  assign io.PB        = sw_q.pb;
  assign io.PC        = sw_q.pc;
  assign io.PD        = sw_q.pd;
  assign io.PI1       = sw_q.pi1;
  assign io.PI2       = sw_q.pi2;
  assign io.PII1      = sw_q.pii1;
  assign io.PII2      = sw_q.pii2;
  assign io.src_n     = src_n_q;
  assign io.snk       = snk_q;
  assign io.preChrg   = pre_q;
  assign io.setupBias = sbias_q;
  assign io.busy      = busy_q;
  assign io.valid     = valid_q;
  assign io.ch_sel    = ch_sel_q;
  assign io.code      = code_q;
  assign io.code_ch   = code_ch_q;

  tmp_chop #(.CHOP_DIV(CHOP_DIV)) u_chop (
    .clk    (clk),
    .reset  (reset),
    .cmp_p1 (io.cmp_p1),
    .cmp_p2 (io.cmp_p2),
    .sample (io.sample)
  );
endmodule

// File: doc/tmp_seq.md
# tmp_seq

Parametrised multi-channel temperature-sensor sequencer. It drives the switched-capacitor phases (precharge, diode, big-diode, H/L charge), the comparator chopper and the source/sink dither. It runs a first-order delta-sigma decision loop and returns one ones-count code per diode channel. It sits between the analog front-end switch matrix and the digital readout, scanning NCH channels once per `start` or continuously.

## Interface
- NCH, 2: number of diode channels (≥1)
- PRE_CYC, 11: precharge length, cycles (≥1)
- DIODE_CYC, 1: DIODE phase length, cycles (≥1)
- BIG_CYC, 5: BIGDIODE phase length, cycles (≥1)
- SETUP_DEC, 6: discarded decisions after each precharge
- OSR_LOG, 6: counted decisions per conversion = 2^OSR_LOG
- CHOP_DIV, 3: chopper half-period, cycles (≥2)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- reset  in  1  async active-high reset
- cmp  in  1  comparator output
- start  in  1  begin scan (sampled in IDLE only)
- cont  in  1  continuous scanning when high
- PI1, PI2, PII1, PII2  out  1 each  diode switch phases
- PA, PB, PC, PD  out  1 each  charge-transfer switches
- src_n, snk  out  1 each  dither source/sink drive
- cmp_p1, cmp_p2  out  1 each  complementary chopper clocks
- sample  out  1  comparator sample strobe
- preChrg, setupBias  out  1 each  precharge / bias-setup enables
- ch_sel  out  NCH  one-hot analog channel select
- busy  out  1  scan in progress
- valid  out  1  one-cycle result strobe
- code  out  OSR_LOG+1  ones count
- code_ch  out  $clog2(NCH) (min 1)  channel of `code`

## Operation
- States: IDLE, PRECHARGE, BLANK_D, DIODE, BLANK_B, BIGDIODE, CHARGE, OUTPUT. All outputs registered.
- IDLE: every phase/switch output is 0; busy=0. `start`=1 → PRECHARGE, channel 0, busy=1.
- PRECHARGE: runs PRE_CYC cycles with preChrg=1, setupBias=1, PB=PC=PD=1 and PA=0. It clears the decision counter, ones counter and the setup counter. Then → BLANK_D.
- BLANK_D and BLANK_B: 1 cycle each, non-overlap gap. All of PA–PD, PI*, PII*, src_n and snk are 0.
- DIODE: DIODE_CYC cycles with PII1=PII2=1. Then → BLANK_B.
- BIGDIODE: BIG_CYC cycles with PI1=PI2=1. Each cycle, src_n toggles if cmp=1, else snk toggles. The decision d is cmp on the last BIGDIODE cycle. Then → CHARGE.
- CHARGE: 1 cycle. d=1 gives PA=PB=1 (H-charge); d=0 gives PA=PC=1 (L-charge).
  - While the setup counter < SETUP_DEC: increment it and discard d. setupBias falls when the counter reaches SETUP_DEC.
  - Otherwise: the ones counter adds d and the decision counter increments.
  - Then → OUTPUT if the decision counter = 2^OSR_LOG, else → BLANK_D.
- OUTPUT: 1 cycle with valid=1, code=ones count, code_ch=channel and PB=PC=PD=1. code and code_ch hold until the next valid.
  - If the channel is not the last: channel+1 → PRECHARGE.
  - If it is the last and cont=1: channel 0 → PRECHARGE.
  - Otherwise → IDLE.
- src_n and snk are forced to 0 outside BIGDIODE.
- ch_sel = one-hot(channel) while busy, 0 in IDLE.
- Chopper is free-running and independent of the FSM:
  - cmp_p1/cmp_p2 toggle every CHOP_DIV cycles.
  - sample=1 in the cycle before each toggle, else 0.

## Timing
- Reset values: state IDLE, channel 0, all counters 0. Every output is 0 except cmp_p2=1. code and code_ch are 0.
- Reset mid-operation aborts immediately (asynchronous). No valid is emitted for a partial conversion.
- `start` is 1 cycle to PRECHARGE entry. `start` is ignored while busy.
- One decision takes DIODE_CYC+BIG_CYC+3 cycles.
- One conversion takes PRE_CYC + (SETUP_DEC+2^OSR_LOG)·(DIODE_CYC+BIG_CYC+3) + 1 cycles.
- `cont` is sampled only in OUTPUT of the last channel. Dropping `cont` mid-scan completes the scan.
- code range is 0 … 2^OSR_LOG inclusive. All-ones gives 2^OSR_LOG, which needs no saturation.
- SETUP_DEC=0: setupBias falls on the first CHARGE cycle, and the first decision counts.
- NCH=1: code_ch stays 0, ch_sel=1 while busy.

## Structure
- Package `tmp_seq_pkg` holds:
  - state enum `tmp_state_t`
  - phase-output struct `tmp_sw_t` (PA–PD, PI1/2, PII1/2)
  - function `decision_cycles(DIODE_CYC, BIG_CYC)`
- Sub-module `tmp_chop` (free-running chopper/sample generator, parameter CHOP_DIV).
- The FSM, counters and result register live in the top level.

## Test plan
- Test configuration: NCH=2, PRE_CYC=4, DIODE_CYC=2, BIG_CYC=3, SETUP_DEC=2, OSR_LOG=3.
- Test 1: reset, then start pulse with cmp=1 constant → valid at cycle 85 after PRECHARGE entry with code=8, code_ch=0. Second valid 85 cycles later with code_ch=1, then IDLE, busy=0.
- Test 2: cmp toggling once per decision (1,0,1,0…) → code=4 for each channel. PA·PB and PA·PC CHARGE cycles alternate. Phase outputs are never high in BLANK_* cycles.
- Test 3: cont=1, then cont dropped during channel 0 → channel 1 completes, then IDLE. With cont held high → channel 0 restarts after channel 1's OUTPUT.
- Test 4: async reset asserted mid-BIGDIODE → all outputs at reset values in the same cycle, no valid, and a later start begins cleanly at channel 0.
- Test 5: chopper check → cmp_p1/cmp_p2 always complementary, period 2·CHOP_DIV, and sample high exactly 1 cycle before each edge. setupBias falls after exactly 2 CHARGE cycles per precharge.
- Test 6: start held high during busy → no restart. cmp=0 constant → code=0, snk toggles during every BIGDIODE cycle, src_n stays 0.
